// File: rtl/flash_readback.sv
// flash_readback: sequential reader for the instruction memory.
// A start pulse walks a word-aligned byte-address range and issues synchronous reads.
// Each word is streamed with its byte address over a valid/ready handshake.
// A two-entry FIFO, together with a bypass for the word arriving from memory,
// keeps at most two words outstanding ahead of the consumer.
// Optional feature: define FLASH_READBACK_CHECKSUM_EN to build a wrapping sum of
// the streamed words on `checksum`; otherwise `checksum` is tied to zero.
module flash_readback #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-2:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]      mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [WIDTH-1:0]      out_data,
  output logic [WIDTH-1:0]      checksum
);

  localparam int CW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = {ADDR_WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      ZERO_WORD  = {WIDTH{1'b0}};
  localparam logic [CW-1:0]         ZERO_CNT   = {CW{1'b0}};
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(3'd4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(2'b11));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]         rem_q, rem_d;          // reads still to issue
  logic                  inflight_q, inflight_d; // memory data arrives this cycle
  logic [ADDR_WIDTH-1:0] land_addr_q, land_addr_d; // address of that arriving word

  logic [WIDTH-1:0]      fifo_data_q [2];
  logic [WIDTH-1:0]      fifo_data_d [2];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;

  logic                  out_valid_s;
  logic [ADDR_WIDTH-1:0] out_addr_s;
  logic [WIDTH-1:0]      out_data_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  pop_fifo_s;
  logic [2:0]            occ_s;
  logic [ADDR_WIDTH-1:0] base_aligned_s;

  assign base_aligned_s = base_addr & ALIGN_MASK;

  // Output head: stored FIFO head first, else the word arriving from memory this cycle.
  always_comb begin
    out_valid_s = 1'b0;
    out_addr_s  = ZERO_ADDR;
    out_data_s  = ZERO_WORD;
    if (fifo_cnt_q != 2'd0) begin
      out_valid_s = 1'b1;
      out_addr_s  = fifo_addr_q[rd_ptr_q];
      out_data_s  = fifo_data_q[rd_ptr_q];
    end else if (inflight_q) begin
      out_valid_s = 1'b1;
      out_addr_s  = land_addr_q;
      out_data_s  = mem_rd_data;
    end else begin
      out_valid_s = 1'b0;
      out_addr_s  = ZERO_ADDR;
      out_data_s  = ZERO_WORD;
    end
  end

  // FIFO bookkeeping: an arriving word is stored unless it is consumed directly on arrival.
  always_comb begin
    pop_s       = out_valid_s && out_ready;
    push_s      = inflight_q && !(pop_s && (fifo_cnt_q == 2'd0));
    pop_fifo_s  = pop_s && (fifo_cnt_q != 2'd0);
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (push_s) begin
      fifo_data_d[wr_ptr_q] = mem_rd_data;
      fifo_addr_d[wr_ptr_q] = land_addr_q;
      wr_ptr_d              = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_fifo_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_fifo_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Sequencer: next state, read issue, and status flags, all decided one cycle ahead.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    rd_addr_d = rd_addr_q;
    if (rd_en_q) begin
      rem_d     = rem_q - CNT_ONE;
      rd_addr_d = rd_addr_q + ADDR_STEP;
    end else begin
      rem_d     = rem_q;
      rd_addr_d = rd_addr_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_addr_d = base_aligned_s;
          rem_d     = word_count;
          state_d   = (word_count == ZERO_CNT) ? S_DONE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rem_d == ZERO_CNT) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if ((fifo_cnt_d == 2'd0) && !rd_en_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Next-cycle occupancy: stored words plus the read issued this cycle.
    occ_s       = {1'b0, fifo_cnt_d} + {2'b00, rd_en_q};
    rd_en_d     = (state_d == S_READ) && (rem_d != ZERO_CNT) && (occ_s < 3'd2);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d == S_READ) || (state_d == S_DRAIN) ||
                  ((state_d == S_DONE) && (state_q == S_DRAIN));
    inflight_d  = rd_en_q;
    land_addr_d = rd_en_q ? rd_addr_q : land_addr_q;
  end

  // Register update; reset flushes the FIFO and drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= ZERO_ADDR;
      rem_q       <= ZERO_CNT;
      inflight_q  <= 1'b0;
      land_addr_q <= ZERO_ADDR;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= ZERO_WORD;
        fifo_addr_q[i] <= ZERO_ADDR;
      end
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      land_addr_q <= land_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_data_q <= fifo_data_d;
      fifo_addr_q <= fifo_addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign out_valid   = out_valid_s;
  assign out_addr    = out_addr_s;
  assign out_data    = out_data_s;

`ifdef FLASH_READBACK_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q, checksum_d;

  // Wrapping sum of consumed words, cleared when a dump is accepted.
  always_comb begin
    if ((state_q == S_IDLE) && start) begin
      checksum_d = ZERO_WORD;
    end else if (pop_s) begin
      checksum_d = checksum_q + out_data_s;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= ZERO_WORD;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = ZERO_WORD;
`endif

endmodule

// File: tb/tb_flash_readback.sv
// Bench for flash_readback: directed dumps against a memory model plus a queue-based
// reference of the expected word stream, checked every cycle on the falling edge.
module tb_flash_readback;

  localparam int WIDTH = 32;
  localparam int AW    = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW-2:0]     word_count;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [WIDTH-1:0]  mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_addr;
  logic [WIDTH-1:0]  out_data;
  logic [WIDTH-1:0]  checksum;

  flash_readback #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic [WIDTH-1:0] mem [512];
  int cyc = 0;
  int t0  = 0;

  // Memory: data one cycle after a read strobe, junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[AW-1:2]];
    else           mem_rd_data <= $urandom();
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  beat_t            exp_q[$];
  logic [AW-1:0]    rd_q[$];
  int               hs_cyc[$];
  logic [AW-1:0]    hs_addr[$];
  logic [WIDTH-1:0] hs_data[$];
  logic [WIDTH-1:0] exp_sum;
  bit               done_seen, any_rd, any_valid, prev_stall;
  int               done_cyc, busy_first, busy_last, rd_count, pop_count;
  logic [AW-1:0]    prev_addr;
  logic [WIDTH-1:0] prev_data;

  task automatic model_clear();
    exp_q.delete(); rd_q.delete(); hs_cyc.delete(); hs_addr.delete(); hs_data.delete();
    exp_sum = 32'h0; done_seen = 1'b0; any_rd = 1'b0; any_valid = 1'b0;
    done_cyc = -1; busy_first = -1; busy_last = -1; rd_count = 0; pop_count = 0;
  endtask

  task automatic model_load(input logic [AW-1:0] b, input logic [AW-2:0] n);
    logic [AW-1:0] a;
    beat_t bt;
    a = b & 11'h7FC;
    for (int i = 0; i < int'(n); i++) begin
      bt.addr = a;
      bt.data = mem[a[AW-1:2]];
      exp_q.push_back(bt);
      rd_q.push_back(a);
      a = a + 11'd4;
    end
  endtask

  function automatic logic ready_for(input int mode, input int rel);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((rel + 1) % 3) == 0;
    return 1'b0;
  endfunction

  // Compare process: every falling edge outside reset.
  initial begin : compare_proc
    int rel;
    int outstanding;
    beat_t hd;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        rel = cyc - t0;
        if (busy) begin
          if (busy_first < 0) busy_first = rel;
          busy_last = rel;
        end
        if (mem_rd_en) begin
          any_rd = 1'b1;
          rd_count++;
          if (rd_q.size() == 0) chk("extra_read", 64'(mem_rd_en), 64'd0);
          else chk("rd_addr", 64'(mem_rd_addr), 64'(rd_q.pop_front()));
        end
        outstanding = rd_count - pop_count;
        chk("outstanding_le_2", 64'(outstanding <= 2), 64'd1);
        if (out_valid) begin
          any_valid = 1'b1;
          if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
        end
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_addr", 64'(out_addr), 64'(prev_addr));
          chk("stall_data", 64'(out_data), 64'(prev_data));
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          hd = exp_q.pop_front();
          chk("out_addr", 64'(out_addr), 64'(hd.addr));
          chk("out_data", 64'(out_data), 64'(hd.data));
          exp_sum = exp_sum + hd.data;
          hs_cyc.push_back(rel);
          hs_addr.push_back(out_addr);
          hs_data.push_back(out_data);
          pop_count++;
        end
        prev_stall = out_valid && !out_ready;
        prev_addr  = out_addr;
        prev_data  = out_data;
        if (done) begin
          done_seen = 1'b1;
          done_cyc  = rel;
          chk("drained_at_done", 64'(exp_q.size()), 64'd0);
`ifdef FLASH_READBACK_CHECKSUM_EN
          chk("checksum_at_done", 64'(checksum), 64'(exp_sum));
`else
          chk("checksum_at_done", 64'(checksum), 64'd0);
`endif
        end
      end
    end
  end

  task automatic run_dump(input logic [AW-1:0] b, input logic [AW-2:0] n, input int mode,
                          input int inj_mid, input bit inj_done);
    int rel;
    @(posedge clk); #1;
    model_clear();
    model_load(b, n);
    t0         = cyc;
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    out_ready  = ready_for(mode, 0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rel   = cyc - t0;
      if (done_seen) break;
      out_ready = ready_for(mode, rel);
      if (inj_mid > 0 && rel == inj_mid) begin
        start = 1'b1; base_addr = 11'h100; word_count = 10'd7;
      end
      if (inj_done && done) start = 1'b1;
    end
    chk("done_seen", 64'(done_seen), 64'd1);
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  logic [WIDTH-1:0] prog [3];

  initial begin : stim
    prog[0] = 32'h02802783; prog[1] = 32'h02802803; prog[2] = 32'h07b00593;
    for (int i = 0; i < 512; i++) mem[i] = 32'h5A000000 + 32'(i * 32'h00010203);
    mem[0] = prog[0]; mem[1] = prog[1]; mem[2] = prog[2];
    mem[511] = 32'hC0FFEE11;
    rst = 1'b1; start = 1'b0; base_addr = 11'h0; word_count = 10'h0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Three-word program, consumer always ready; start again while in DONE.
    run_dump(11'h000, 10'd3, 0, 0, 1'b1);
    chk("t1_nwords", 64'(hs_cyc.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_hs_cycle", 64'(hs_cyc[i]), 64'(i + 2));
      chk("t1_hs_addr", 64'(hs_addr[i]), 64'(4 * i));
      chk("t1_hs_data", 64'(hs_data[i]), 64'(prog[i]));
    end
    chk("t1_done_cycle", 64'(done_cyc), 64'd5);
    chk("t1_busy_first", 64'(busy_first), 64'd1);
    chk("t1_busy_last", 64'(busy_last), 64'd5);
`ifdef FLASH_READBACK_CHECKSUM_EN
    chk("t1_checksum", 64'(checksum), 64'h0CB05519);
`else
    chk("t1_checksum", 64'(checksum), 64'd0);
`endif
    repeat (3) @(negedge clk);

    // Same dump with the consumer stalling in a 1,0,0 pattern.
    run_dump(11'h000, 10'd3, 1, 0, 1'b0);
    chk("t2_nwords", 64'(hs_data.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("t2_hs_data", 64'(hs_data[i]), 64'(prog[i]));
`ifdef FLASH_READBACK_CHECKSUM_EN
    chk("t2_checksum", 64'(checksum), 64'h0CB05519);
`endif

    // Address wrap at the top of the memory.
    run_dump(11'h7FC, 10'd2, 0, 0, 1'b0);
    chk("t3_nwords", 64'(hs_addr.size()), 64'd2);
    chk("t3_addr0", 64'(hs_addr[0]), 64'h7FC);
    chk("t3_addr1", 64'(hs_addr[1]), 64'h000);
    chk("t3_data0", 64'(hs_data[0]), 64'hC0FFEE11);

    // Zero-length dump.
    run_dump(11'h040, 10'd0, 0, 0, 1'b0);
    chk("t4_done_cycle", 64'(done_cyc), 64'd1);
    chk("t4_no_read", 64'(any_rd), 64'd0);
    chk("t4_no_valid", 64'(any_valid), 64'd0);
    chk("t4_busy_never", 64'(busy_first), 64'hFFFF_FFFF_FFFF_FFFF);

    // Start pulsed mid-dump must be ignored.
    run_dump(11'h040, 10'd5, 1, 3, 1'b0);
    chk("t5_nwords", 64'(hs_data.size()), 64'd5);
    repeat (5) @(negedge clk);
    chk("t5_idle_after", 64'(busy), 64'd0);

    // Reset mid-dump with a read in flight.
    @(posedge clk); #1;
    model_clear();
    model_load(11'h020, 10'd4);
    t0 = cyc; start = 1'b1; base_addr = 11'h020; word_count = 10'd4; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk("t6_read_in_flight", 64'(mem_rd_en), 64'd1);
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_rd_en", 64'(mem_rd_en), 64'd0);
    chk("t6_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_out_addr", 64'(out_addr), 64'd0);
    chk("t6_out_data", 64'(out_data), 64'd0);
    chk("t6_checksum", 64'(checksum), 64'd0);
    repeat (3) @(negedge clk);
    run_dump(11'h010, 10'd2, 0, 0, 1'b0);
    chk("t6_fresh_nwords", 64'(hs_addr.size()), 64'd2);
    chk("t6_fresh_addr0", 64'(hs_addr[0]), 64'h010);

    // Misaligned base is aligned down.
    run_dump(11'h00A, 10'd1, 0, 0, 1'b0);
    chk("t7_nwords", 64'(hs_addr.size()), 64'd1);
    chk("t7_addr", 64'(hs_addr[0]), 64'h008);
    chk("t7_data", 64'(hs_data[0]), 64'h07b00593);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
